mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter that shares one single-port, variable-latency memory between the pipeline's instruction-fetch port and data-memory port. It sits between the datapath's instruction and data memory buses and the unified memory. It serialises the two request streams and returns read data with a one-cycle done pulse. It also produces the stall qualifiers that freeze the fetch and memory stages while their access is outstanding.

## Interface
Parameters:
- MAX_WAIT, 15: number of cycles to wait for m_ack before aborting; legal range 1..255.
- STARVE_LIM, 2: number of consecutive data grants allowed while i_req is pending before instruction gets priority.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch read request; held until i_done.
- i_addr  in  32  fetch address; stable while i_req is high.
- i_rdata  out  32  fetched word; valid when i_done is high, then held.
- i_done  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  32  data address; stable while d_req is high.
- d_wdata  in  32  store data; stable while d_req is high.
- d_rdata  out  32  load data; valid when d_done is high.
- d_done  out  1  one-cycle completion pulse.
- m_req  out  1  memory request; held until m_ack or abort.
- m_we  out  1  memory write enable.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_ack  in  1  memory completion; m_rdata is valid in the same cycle.
- m_rdata  in  32  memory read data.
- stall_F  out  1  combinational: i_req & ~i_done.
- stall_M  out  1  combinational: d_req & ~d_done.
- timeout_err  out  1  sticky abort flag; cleared only by reset.

## Operation
- The FSM has four states: IDLE, BUSY_I, BUSY_D, RESP.
- In IDLE, the arbiter samples the requests:
  - d_req only: go to BUSY_D.
  - i_req only: go to BUSY_I.
  - Both requests: go to BUSY_D, unless starve_cnt == STARVE_LIM, in which case go to BUSY_I.
  - Neither request: stay in IDLE.
- On entering BUSY_x, the arbiter registers m_addr, m_we and m_wdata from the granted port and sets m_req = 1. For a fetch grant, m_we = 0 and m_wdata = 0.
- In BUSY_x with m_ack = 1:
  - Capture m_rdata into x_rdata. For a data write, capture 0 into d_rdata instead.
  - Drop m_req.
  - Pulse x_done in the next cycle (RESP).
- In BUSY_x with m_ack = 0: increment wait_cnt. When wait_cnt == MAX_WAIT, abort:
  - Drop m_req.
  - Set x_rdata = 0.
  - Set timeout_err = 1.
  - Go to RESP and pulse x_done.
- RESP: x_done = 1 for exactly one cycle, no new grant is issued, and the next state is always IDLE. The requester may keep x_req high for a back-to-back access; it is sampled in that following IDLE.
- starve_cnt:
  - Increments on each data grant made while i_req = 1.
  - Resets to 0 on any instruction grant.
  - Resets to 0 on a data grant made while i_req = 0.
  - Saturates at STARVE_LIM.
- The idle port's rdata holds its last value. A done pulse is only ever issued for the port that was granted.
- wait_cnt is 8 bits and is cleared on every grant.

## Timing
- Reset values: all registered outputs are 0 (m_req, m_we, m_addr, m_wdata, i_rdata, d_rdata, i_done, d_done, timeout_err), state = IDLE, starve_cnt = 0, wait_cnt = 0.
- Reset asserted mid-transaction: the next edge forces IDLE and m_req = 0, and no done pulse is issued. The memory must tolerate a withdrawn request.
- Latency: request high at cycle 0 (IDLE) → m_req high at cycle 1 → m_ack at cycle k ≥ 1 → done at cycle k+1. The minimum is a done at cycle 2.
- Throughput: at most one access per 3 cycles (IDLE, BUSY, RESP).
- m_req stays high continuously from grant until the ack cycle (inclusive) or the abort cycle (inclusive). m_addr, m_we and m_wdata are constant throughout.
- An m_ack arriving while not in BUSY is ignored.
- An abort occurs MAX_WAIT+1 cycles after the grant edge if no ack arrives. An ack that arrives in the abort cycle wins: the access completes normally and no error is flagged.
- stall_F and stall_M are combinational from req and done only; there is no path from m_ack to them.

## Test plan
- Lone fetch: i_req=1, i_addr=0x40, memory acks 1 cycle after m_req with 0x8C010004 → m_req high cycles 1–2, i_done pulses at cycle 3 with i_rdata=0x8C010004, stall_F high for cycles 0–2.
- Store then load: d_req with d_we=1, addr 0x100, wdata 0xCAFEF00D; then a load from 0x100 with a memory model → write completes with d_rdata=0, load returns 0xCAFEF00D, m_we=1 only during the store.
- Contention and starvation: i_req and d_req both held high through repeated d transactions, STARVE_LIM=2 → grants go D, D, I, D, D, I …, and every grant is separated by a RESP cycle.
- Timeout: MAX_WAIT=15, memory never acks a data read → m_req drops after 16 cycles in BUSY, d_done pulses with d_rdata=0, timeout_err=1 and stays 1 after a following successful fetch until reset.
- Ack on the boundary: ack arrives exactly in the abort cycle with data 0x12345678 → normal completion, timeout_err stays 0.
- Reset mid-op: reset asserted at cycle 2 of a pending fetch → m_req=0 and state IDLE the next cycle, no i_done pulse, all outputs 0. After reset is released with i_req still high, a fresh grant follows normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one single-port, variable-latency memory between the fetch and data ports.
// Serialises requests, returns read data with a one-cycle done pulse, and aborts stalled accesses.
module mem_arbiter #(
   parameter int MAX_WAIT   = 15,
   parameter int STARVE_LIM = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_done,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_ack,
   input  logic [31:0] m_rdata,
   output logic        stall_F,
   output logic        stall_M,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

   localparam logic [7:0] MAX_WAIT_C   = 8'(MAX_WAIT);
   localparam logic [7:0] STARVE_LIM_C = 8'(STARVE_LIM);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] starve_cnt;
   logic       busy;
   logic       grant_i, grant_d;
   logic       finish, abort;

   assign busy    = (state == BUSY_I) || (state == BUSY_D);
   assign stall_F = i_req & ~i_done;
   assign stall_M = d_req & ~d_done;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values together.
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      finish    = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            // Data wins contention until it has starved fetch STARVE_LIM times in a row.
            if (d_req && !(i_req && starve_cnt == STARVE_LIM_C)) begin
               grant_d   = 1'b1;
               state_nxt = BUSY_D;
            end else if (i_req) begin
               grant_i   = 1'b1;
               state_nxt = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (m_ack) begin
               finish    = 1'b1;
               state_nxt = RESP;
            end else if (wait_cnt == MAX_WAIT_C) begin
               abort     = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_req       <= 1'b0;
         m_we        <= 1'b0;
         m_addr      <= '0;
         m_wdata     <= '0;
         i_rdata     <= '0;
         d_rdata     <= '0;
         i_done      <= 1'b0;
         d_done      <= 1'b0;
         timeout_err <= 1'b0;
         wait_cnt    <= '0;
         starve_cnt  <= '0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;

         if (grant_i) begin
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= i_addr;
            m_wdata    <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
         end

         if (grant_d) begin
            m_req    <= 1'b1;
            m_we     <= d_we;
            m_addr   <= d_addr;
            m_wdata  <= d_wdata;
            wait_cnt <= '0;
            if (!i_req)                           starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM_C) starve_cnt <= starve_cnt + 8'd1;
         end

         if (busy && !finish && !abort) wait_cnt <= wait_cnt + 8'd1;

         if (finish || abort) begin
            m_req <= 1'b0;
            if (state == BUSY_I) begin
               i_rdata <= finish ? m_rdata : '0;
               i_done  <= 1'b1;
            end else begin
               // A completed write returns zero rather than whatever the bus carried.
               d_rdata <= (finish && !m_we) ? m_rdata : '0;
               d_done  <= 1'b1;
            end
         end

         if (abort) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model compared every cycle,
// a reactive memory responder, and directed scenarios with literal expectations.
module tb_mem_arbiter;

   localparam int MAX_WAIT   = 15;
   localparam int STARVE_LIM = 2;
   localparam logic [31:0] D_ADDR_C = 32'h0000_0300;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_ack;
   logic [31:0] m_rdata;
   logic        stall_F;
   logic        stall_M;
   logic        timeout_err;

   logic        resp_ack;
   logic        stray_ack;
   int          ack_wait;
   int          req_age;
   bit   [31:0] mem [bit [31:0]];

   int checks = 0;
   int errors = 0;

   typedef enum {OWN_NONE, OWN_I, OWN_D} owner_t;
   owner_t      owner = OWN_NONE;
   int          grant_cyc = 0;
   int          starve = 0;
   int          cyc = 0;
   logic        e_mreq = 0, e_mwe = 0, e_idone = 0, e_ddone = 0, e_terr = 0;
   logic [31:0] e_maddr = 0, e_mwdata = 0, e_irdata = 0, e_drdata = 0;

   string       glog = "";
   int          gcyc[$];
   logic        prev_mreq = 0;

   assign m_ack = resp_ack | stray_ack;

   mem_arbiter #(.MAX_WAIT(MAX_WAIT), .STARVE_LIM(STARVE_LIM)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata),
      .stall_F(stall_F), .stall_M(stall_M), .timeout_err(timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_s(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
      end
   endtask

   // Memory: acks after ack_wait idle request cycles (never when negative); writes land on ack.
   initial begin
      resp_ack   = 1'b0;
      m_rdata    = 32'hFFFF_FFFF;
      req_age    = 0;
      forever begin
         @(posedge clk);
         #1;
         resp_ack = 1'b0;
         m_rdata  = 32'hFFFF_FFFF;
         if (!m_req) begin
            req_age = 0;
         end else begin
            if (ack_wait >= 0 && req_age == ack_wait) begin
               resp_ack = 1'b1;
               if (m_we) begin
                  mem[m_addr] = m_wdata;
                  m_rdata     = 32'hDEAD_BEEF;
               end else begin
                  m_rdata = mem.exists(m_addr) ? mem[m_addr] : 32'h0;
               end
            end
            req_age++;
         end
      end
   end

   // Reference model: one step per cycle, using the inputs the next rising edge will sample.
   task automatic model_step();
      bit in_resp;
      in_resp = e_idone | e_ddone;
      if (reset) begin
         {e_mreq, e_mwe, e_idone, e_ddone, e_terr} = '0;
         {e_maddr, e_mwdata, e_irdata, e_drdata}   = '0;
         owner  = OWN_NONE;
         starve = 0;
         return;
      end
      e_idone = 1'b0;
      e_ddone = 1'b0;
      if (in_resp) return;
      if (owner == OWN_NONE) begin
         if (d_req && !(i_req && starve == STARVE_LIM)) begin
            owner    = OWN_D;
            e_mreq   = 1'b1;
            e_mwe    = d_we;
            e_maddr  = d_addr;
            e_mwdata = d_wdata;
            starve   = i_req ? ((starve < STARVE_LIM) ? starve + 1 : starve) : 0;
            grant_cyc = cyc;
         end else if (i_req) begin
            owner    = OWN_I;
            e_mreq   = 1'b1;
            e_mwe    = 1'b0;
            e_maddr  = i_addr;
            e_mwdata = 32'h0;
            starve   = 0;
            grant_cyc = cyc;
         end
      end else if (m_ack || (cyc - grant_cyc) == MAX_WAIT + 1) begin
         if (owner == OWN_I) begin
            e_irdata = m_ack ? m_rdata : 32'h0;
            e_idone  = 1'b1;
         end else begin
            e_drdata = (m_ack && !e_mwe) ? m_rdata : 32'h0;
            e_ddone  = 1'b1;
         end
         if (!m_ack) e_terr = 1'b1;
         e_mreq = 1'b0;
         owner  = OWN_NONE;
      end
   endtask

   // Compare process: mid-cycle, every output against the model, then advance the model.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         check1("m_req", m_req, e_mreq);
         check1("m_we", m_we, e_mwe);
         check("m_addr", m_addr, e_maddr);
         check("m_wdata", m_wdata, e_mwdata);
         check1("i_done", i_done, e_idone);
         check1("d_done", d_done, e_ddone);
         check("i_rdata", i_rdata, e_irdata);
         check("d_rdata", d_rdata, e_drdata);
         check1("timeout_err", timeout_err, e_terr);
         check1("stall_F", stall_F, i_req & ~e_idone);
         check1("stall_M", stall_M, d_req & ~e_ddone);
         if (m_req && !prev_mreq) begin
            if (m_addr == D_ADDR_C) glog = {glog, "D"};
            else                    glog = {glog, "I"};
            gcyc.push_back(cyc);
         end
         prev_mreq = m_req;
         model_step();
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic run_until_done(input string name, input bit port_d, input int limit,
                                 output int n, output int mc);
      bit seen;
      seen = 1'b0;
      n    = 0;
      mc   = 0;
      while (!seen && n < limit) begin
         tick();
         n++;
         if (m_req) mc++;
         seen = port_d ? d_done : i_done;
      end
      check1(name, seen, 1'b1);
   endtask

   initial begin
      int    n, mc, g0;
      string order;
      reset = 1'b1;  i_req = 1'b0; i_addr = '0;
      d_req = 1'b0;  d_we = 1'b0;  d_addr = '0; d_wdata = '0;
      stray_ack = 1'b0; ack_wait = 0;
      mem[32'h40]  = 32'h8C01_0004;
      mem[32'h80]  = 32'h0BAD_C0DE;
      mem[32'h200] = 32'h2222_2222;
      mem[32'h300] = 32'h3333_3333;
      mem[32'h600] = 32'h1234_5678;
      tick();
      tick();
      check1("rst_m_req", m_req, 1'b0);
      check1("rst_timeout_err", timeout_err, 1'b0);
      check("rst_m_addr", m_addr, 32'h0);
      check("rst_i_rdata", i_rdata, 32'h0);
      reset = 1'b0;
      tick();

      // Lone fetch: ack in the second request cycle.
      ack_wait = 1; i_req = 1'b1; i_addr = 32'h40;
      run_until_done("fetch_done_seen", 1'b0, 10, n, mc);
      check("fetch_done_cycle", 32'(n), 32'd3);
      check("fetch_mreq_cycles", 32'(mc), 32'd2);
      check("fetch_rdata", i_rdata, 32'h8C01_0004);
      check1("fetch_stall_F_at_done", stall_F, 1'b0);
      i_req = 1'b0;
      tick();

      // Store then load of the same word.
      ack_wait = 2; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
      tick();
      check1("store_m_we", m_we, 1'b1);
      check("store_m_wdata", m_wdata, 32'hCAFE_F00D);
      run_until_done("store_done_seen", 1'b1, 10, n, mc);
      check("store_d_rdata", d_rdata, 32'h0);
      d_req = 1'b0;
      tick();
      d_req = 1'b1; d_we = 1'b0; d_wdata = '0;
      tick();
      check1("load_m_we", m_we, 1'b0);
      run_until_done("load_done_seen", 1'b1, 10, n, mc);
      check("load_d_rdata", d_rdata, 32'hCAFE_F00D);
      d_req = 1'b0;
      tick();

      // Contention: both ports held high across back-to-back accesses.
      ack_wait = 0; g0 = glog.len();
      i_addr = 32'h200; d_addr = D_ADDR_C; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      n = 0;
      while (!(glog.len() >= g0 + 6 && i_done) && n < 60) begin
         tick();
         n++;
      end
      check1("contention_complete", glog.len() >= g0 + 6 && i_done, 1'b1);
      order = (glog.len() >= g0 + 6) ? glog.substr(g0, g0 + 5) : glog.substr(g0, glog.len() - 1);
      check_s("grant_order", order, "DDIDDI");
      for (int k = 0; k < 5; k++)
         if (gcyc.size() > g0 + k + 1)
            check("grant_spacing", 32'(gcyc[g0 + k + 1] - gcyc[g0 + k]), 32'd3);
      check("contention_i_rdata", i_rdata, 32'h2222_2222);
      check("contention_d_rdata", d_rdata, 32'h3333_3333);
      i_req = 1'b0; d_req = 1'b0;
      tick();
      tick();

      // A stray ack while idle must be ignored.
      stray_ack = 1'b1;
      tick();
      stray_ack = 1'b0;
      check1("stray_m_req", m_req, 1'b0);
      tick();
      check1("stray_d_done", d_done, 1'b0);
      check("stray_d_rdata", d_rdata, 32'h3333_3333);

      // Ack arrives exactly in the abort cycle: normal completion.
      ack_wait = MAX_WAIT; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
      run_until_done("boundary_done_seen", 1'b1, 40, n, mc);
      check("boundary_mreq_cycles", 32'(mc), 32'd16);
      check("boundary_d_rdata", d_rdata, 32'h1234_5678);
      check1("boundary_timeout_err", timeout_err, 1'b0);
      d_req = 1'b0;
      tick();

      // Timeout: memory never acks a data read.
      ack_wait = -1; d_req = 1'b1; d_addr = 32'h500;
      run_until_done("timeout_done_seen", 1'b1, 40, n, mc);
      check("timeout_done_cycle", 32'(n), 32'd17);
      check("timeout_mreq_cycles", 32'(mc), 32'd16);
      check("timeout_d_rdata", d_rdata, 32'h0);
      check1("timeout_err_set", timeout_err, 1'b1);
      d_req = 1'b0;
      tick();
      ack_wait = 0; i_req = 1'b1; i_addr = 32'h40;
      run_until_done("post_timeout_fetch_seen", 1'b0, 10, n, mc);
      check("min_latency_cycle", 32'(n), 32'd2);
      check("post_timeout_i_rdata", i_rdata, 32'h8C01_0004);
      check1("timeout_err_sticky", timeout_err, 1'b1);
      i_req = 1'b0;
      tick();

      // Reset in the middle of a pending fetch.
      ack_wait = -1; i_req = 1'b1; i_addr = 32'h80;
      tick();
      check1("midop_m_req_c1", m_req, 1'b1);
      tick();
      reset = 1'b1;
      tick();
      check1("midop_m_req_after_rst", m_req, 1'b0);
      check1("midop_i_done_after_rst", i_done, 1'b0);
      check1("midop_timeout_cleared", timeout_err, 1'b0);
      check("midop_i_rdata_after_rst", i_rdata, 32'h0);
      check("midop_d_rdata_after_rst", d_rdata, 32'h0);
      check("midop_m_addr_after_rst", m_addr, 32'h0);
      reset = 1'b0; ack_wait = 0;
      run_until_done("midop_refetch_seen", 1'b0, 10, n, mc);
      check("midop_refetch_cycle", 32'(n), 32'd2);
      check("midop_refetch_rdata", i_rdata, 32'h0BAD_C0DE);
      i_req = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
